rf_wb_arbiter: RTL and testbench

Write-port controller for the 16x32 register bank.
- Shares the bank's single write port between two writeback requesters: the ALU result path and the memory-load path.
- Owns the register scoreboard that flags a pending destination register to the decode stage.
- Drives the bank's write, addrw and datain inputs directly, from registered outputs. The bank's rst and clk come from the same nets as this block's.

---
 rtl/rf_wb_arbiter.sv | 94 +++++++++
 tb/tb_rf_wb_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Write-port arbiter for the 16x32 register bank: ALU vs. load writeback,
// with starvation guard for the ALU and a destination-register scoreboard.
module rf_wb_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_addr,
  input  logic [DW-1:0]   alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_busy,
  output logic [2**AW-1:0] busy_vec,
  output logic            rf_write,
  output logic [AW-1:0]   rf_addrw,
  output logic [DW-1:0]   rf_datain
);
  localparam int STAGES = 1;
  localparam int SW     = 4;
  localparam int NREG   = 2**AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

  logic [SW-1:0]     starve;
  logic              alu_pri, gnt_alu, gnt_mem, accept;
  wb_req_t           req_sel, req_q;
  logic [STAGES:0]   vld_pipe;
  logic [NREG-1:0]   busy_nxt;

  // ALU wins outright once it has lost STARVE_MAX times in a row.
  assign alu_pri = alu_valid && (starve == SW'(STARVE_MAX));
  assign gnt_alu = alu_pri || (alu_valid && !mem_valid);
  assign gnt_mem = mem_valid && !alu_pri;
  assign accept  = gnt_alu || gnt_mem;

  assign alu_ready = gnt_alu;
  assign mem_ready = gnt_mem;

  always_comb begin
    req_sel = '0;
    if (gnt_alu)      req_sel = '{addr: alu_addr, data: alu_data};
    else if (gnt_mem) req_sel = '{addr: mem_addr, data: mem_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        starve <= '0;
    else if (gnt_alu)                starve <= '0;
    else if (gnt_mem && alu_valid && starve != SW'(STARVE_MAX))
                                     starve <= starve + SW'(1);
  end

  assign vld_pipe[0] = accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe[STAGES:1] <= '0;
      req_q              <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (accept) req_q <= req_sel;
    end
  end

  assign rf_write  = vld_pipe[STAGES];
  assign rf_addrw  = req_q.addr;
  assign rf_datain = req_q.data;

  // Clear at acceptance, then set: a same-edge issue to the same register
  // is a newer producer and must stay pending.
  always_comb begin
    busy_nxt = busy_vec;
    if (accept)    busy_nxt[req_sel.addr] = 1'b0;
    if (iss_valid) busy_nxt[iss_addr]     = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_vec <= '0;
    else      busy_vec <= busy_nxt;
  end

  assign rd_busy = busy_vec[rd_addr];
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, single write, contention,
// scoreboard set/clear and same-destination ordering.
module tb_rf_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, mem_valid, iss_valid;
  logic            alu_ready, mem_ready, rd_busy, rf_write;
  logic [AW-1:0]   alu_addr, mem_addr, iss_addr, rd_addr, rf_addrw;
  logic [DW-1:0]   alu_data, mem_data, rf_datain;
  logic [2**AW-1:0] busy_vec;

  int npass = 0;
  int ntot  = 0;

  rf_wb_arbiter #(.DW(DW), .AW(AW), .STARVE_MAX(3)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .rd_addr(rd_addr), .rd_busy(rd_busy),
    .busy_vec(busy_vec), .rf_write(rf_write), .rf_addrw(rf_addrw), .rf_datain(rf_datain)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 0; mem_valid = 0; iss_valid = 0;
    alu_addr = '0; mem_addr = '0; iss_addr = '0; rd_addr = '0;
    alu_data = '0; mem_data = '0;
    tick(); tick();
    chk("rst_write", rf_write, 0);
    chk("rst_addrw", rf_addrw, 0);
    chk("rst_datain", rf_datain, 0);
    chk("rst_busy", busy_vec, 0);
    rst = 1'b1;
    tick();

    // single ALU request
    alu_valid = 1; alu_addr = 3; alu_data = 32'h12345678;
    #1;
    chk("single_alu_ready", alu_ready, 1);
    chk("single_mem_ready", mem_ready, 0);
    tick();
    alu_valid = 0;
    #1;
    chk("single_write", rf_write, 1);
    chk("single_addrw", rf_addrw, 3);
    chk("single_datain", rf_datain, 32'h12345678);
    tick();
    chk("single_write_off", rf_write, 0);
    chk("single_datain_hold", rf_datain, 32'h12345678);

    // reset mid-write, with a same-edge issue to the same register pending
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
    iss_valid = 1; iss_addr = 5;
    tick();
    alu_valid = 0; iss_valid = 0;
    chk("midrst_write_pre", rf_write, 1);
    chk("midrst_busy5_pre", busy_vec[5], 1);
    rst = 1'b0;
    #1;
    chk("midrst_write", rf_write, 0);
    chk("midrst_datain", rf_datain, 0);
    chk("midrst_busy", busy_vec, 0);
    tick();
    chk("midrst_no_write", rf_write, 0);
    rst = 1'b1;
    tick();

    // contention: grant sequence M,M,M,A,M,M,M,A
    alu_valid = 1; alu_addr = 15; alu_data = 32'hAAAA0000;
    mem_valid = 1;
    for (int i = 0; i < 8; i++) begin
      logic exp_a;
      exp_a = (i == 3) || (i == 7);
      mem_addr = AW'(i); mem_data = 32'h100 + i;
      #1;
      chk($sformatf("cont_alu_ready%0d", i), alu_ready, exp_a);
      chk($sformatf("cont_mem_ready%0d", i), mem_ready, !exp_a);
      tick();
      chk($sformatf("cont_addrw%0d", i), rf_addrw, exp_a ? 15 : i);
    end
    alu_valid = 0; mem_valid = 0;
    tick();

    // scoreboard set then clear by a load
    iss_valid = 1; iss_addr = 7; rd_addr = 7;
    tick();
    iss_valid = 0;
    chk("sb_busy_set", rd_busy, 1);
    tick(); tick(); tick();
    chk("sb_busy_hold", rd_busy, 1);
    mem_valid = 1; mem_addr = 7; mem_data = 32'h77;
    #1;
    chk("sb_mem_ready", mem_ready, 1);
    tick();
    mem_valid = 0;
    #1;
    chk("sb_busy_clr", rd_busy, 0);
    chk("sb_write", rf_write, 1);
    chk("sb_addrw", rf_addrw, 7);

    // set and clear on different addresses in one edge
    iss_valid = 1; iss_addr = 4;
    tick();
    iss_addr = 6; alu_valid = 1; alu_addr = 4; alu_data = 32'h44;
    tick();
    chk("sb_diff_clr4", busy_vec[4], 0);
    chk("sb_diff_set6", busy_vec[6], 1);

    // set and clear on the same address: set wins
    iss_addr = 9; alu_addr = 9; alu_data = 32'h99;
    tick();
    iss_valid = 0; alu_valid = 0; rd_addr = 9;
    #1;
    chk("sb_same_busy9", busy_vec[9], 1);
    chk("sb_same_rd_busy", rd_busy, 1);
    tick();

    // same destination from both requesters: MEM first, ALU last
    alu_valid = 1; alu_addr = 2; alu_data = 32'hA;
    mem_valid = 1; mem_addr = 2; mem_data = 32'hB;
    #1;
    chk("dest_mem_first", mem_ready, 1);
    chk("dest_alu_wait", alu_ready, 0);
    tick();
    mem_valid = 0;
    #1;
    chk("dest_alu_next", alu_ready, 1);
    chk("dest_w1", rf_write, 1);
    chk("dest_d1", rf_datain, 32'hB);
    tick();
    alu_valid = 0;
    chk("dest_w2", rf_write, 1);
    chk("dest_a2", rf_addrw, 2);
    chk("dest_d2", rf_datain, 32'hA);
    tick();
    chk("dest_w_off", rf_write, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
